// File: rtl/ifu_fetch_pkg.sv
// Shared configuration for the instruction-fetch front end.
// Holds the width defaults, the reset PC and the 3-bit FSM state encoding.
package ifu_fetch_pkg;

   localparam int          ISA_WIDTH_DEF = 32;
   localparam logic [31:0] RESET_PC_DEF  = 32'h8000_0000;
   localparam int          INST_WIDTH    = 32;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_REQ   = 3'd1;
   localparam logic [2:0] ST_WAIT  = 3'd2;
   localparam logic [2:0] ST_HOLD  = 3'd3;
   localparam logic [2:0] ST_EXEC  = 3'd4;
   localparam logic [2:0] ST_FAULT = 3'd5;

   // Instructions are word aligned, so the two low PC bits must be clear.
   function automatic logic pc_is_aligned(input logic [1:0] pc_low);
      return (pc_low == 2'b00);
   endfunction

endpackage

// File: rtl/ifu_pc_reg.sv
// Architectural PC register with asynchronous reset to the boot address.
// The fetch FSM decides when a new PC is committed through load_en.
module ifu_pc_reg
   import ifu_fetch_pkg::*;
#(
   parameter int                 WIDTH     = ISA_WIDTH_DEF,
   parameter logic [WIDTH-1:0]   RESET_VAL = WIDTH'(RESET_PC_DEF)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_en,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] pc_q
);

   logic [WIDTH-1:0] pc_d;

   always_comb begin
      pc_d = pc_q;
      if (load_en) begin
         pc_d = load_val;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q <= RESET_VAL;
      end else begin
         pc_q <= pc_d;
      end
   end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction-fetch front end: owns the PC, issues one memory request per
// instruction, holds the fetched word for decode and halts on any fault.
module ifu_fetch
   import ifu_fetch_pkg::*;
#(
   parameter int                   ISA_WIDTH = ISA_WIDTH_DEF,
   parameter logic [ISA_WIDTH-1:0] RESET_PC  = ISA_WIDTH'(RESET_PC_DEF)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ISA_WIDTH-1:0]  pc_in,
   input  logic                  pc_w_en,
   output logic [ISA_WIDTH-1:0]  pc_out,
   output logic                  imem_req_valid,
   output logic [ISA_WIDTH-1:0]  imem_req_addr,
   input  logic                  imem_req_ready,
   input  logic                  imem_resp_valid,
   input  logic [INST_WIDTH-1:0] imem_resp_data,
   input  logic                  imem_resp_err,
   output logic                  inst_valid,
   output logic [INST_WIDTH-1:0] inst,
   input  logic                  inst_ready,
   output logic                  fetch_fault
);

   logic [2:0]            state_q, state_d;
   logic [INST_WIDTH-1:0] inst_q, inst_d;
   logic                  pc_load;
   logic [ISA_WIDTH-1:0]  pc_q;

   ifu_pc_reg #(
      .WIDTH     (ISA_WIDTH),
      .RESET_VAL (RESET_PC)
   ) u_pc_reg (
      .clk      (clk),
      .rst      (rst),
      .load_en  (pc_load),
      .load_val (pc_in),
      .pc_q     (pc_q)
   );

   // pc_w_en only matters in EXEC; every other state ignores it, which keeps
   // the PC stable for the whole life of an outstanding fetch.
   always_comb begin
      state_d = state_q;
      inst_d  = inst_q;
      pc_load = 1'b0;
      case (state_q)
         ST_IDLE: begin
            state_d = ST_REQ;
         end
         ST_REQ: begin
            if (imem_req_ready) begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (imem_resp_valid) begin
               if (imem_resp_err) begin
                  state_d = ST_FAULT;
               end else begin
                  inst_d  = imem_resp_data;
                  state_d = ST_HOLD;
               end
            end
         end
         ST_HOLD: begin
            if (inst_ready) begin
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            if (pc_w_en) begin
               if (pc_is_aligned(pc_in[1:0])) begin
                  pc_load = 1'b1;
                  state_d = ST_REQ;
               end else begin
                  state_d = ST_FAULT;
               end
            end
         end
         ST_FAULT: begin
            state_d = ST_FAULT;
         end
         default: begin
            state_d = ST_FAULT;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         inst_q  <= '0;
      end else begin
         state_q <= state_d;
         inst_q  <= inst_d;
      end
   end

   // Outputs decode straight from state flops, so an async reset clears them
   // in the same cycle without waiting for a clock edge.
   always_comb begin
      pc_out         = pc_q;
      imem_req_addr  = pc_q;
      imem_req_valid = (state_q == ST_REQ);
      inst_valid     = (state_q == ST_HOLD);
      inst           = inst_q;
      fetch_fault    = (state_q == ST_FAULT);
   end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed self-checking bench for ifu_fetch: fetch, stall, jump, ignored
// commit strobes, misaligned/err faults and asynchronous reset mid-fetch.
module tb_ifu_fetch;

   logic        clock;
   logic        reset;
   logic [31:0] pcIn;
   logic        pcWEn;
   logic [31:0] pcOut;
   logic        reqValid;
   logic [31:0] reqAddr;
   logic        reqReady;
   logic        respValid;
   logic [31:0] respData;
   logic        respErr;
   logic        instValid;
   logic [31:0] instWord;
   logic        instReady;
   logic        fetchFault;

   int assertCount = 0;
   int failCount   = 0;
   int acceptCount = 0;

   ifu_fetch dut (
      .clk             (clock),
      .rst             (reset),
      .pc_in           (pcIn),
      .pc_w_en         (pcWEn),
      .pc_out          (pcOut),
      .imem_req_valid  (reqValid),
      .imem_req_addr   (reqAddr),
      .imem_req_ready  (reqReady),
      .imem_resp_valid (respValid),
      .imem_resp_data  (respData),
      .imem_resp_err   (respErr),
      .inst_valid      (instValid),
      .inst            (instWord),
      .inst_ready      (instReady),
      .fetch_fault     (fetchFault)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Counts request handshakes as seen at the active edge.
   always @(posedge clock) begin
      if (!reset && reqValid && reqReady) begin
         acceptCount <= acceptCount + 1;
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
      end
   endtask

   // Drives one cycle of inputs, clocks once, and leaves time 1ns past the edge.
   task automatic applyStimulus(input logic rdy, input logic rv, input logic re,
                                input logic [31:0] rd, input logic ir,
                                input logic we, input logic [31:0] pc);
      reqReady  = rdy;
      respValid = rv;
      respErr   = re;
      respData  = rd;
      instReady = ir;
      pcWEn     = we;
      pcIn      = pc;
      @(posedge clock);
      #1;
   endtask

   task automatic doReset();
      reset = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      pcIn = '0; pcWEn = 1'b0; reqReady = 1'b0;
      respValid = 1'b0; respData = '0; respErr = 1'b0; instReady = 1'b0;
      @(posedge clock); #1;
      @(posedge clock); #1;

      checkOutput("rst_pc",      pcOut,      32'h8000_0000);
      checkOutput("rst_reqv",    reqValid,   1'b0);
      checkOutput("rst_instv",   instValid,  1'b0);
      checkOutput("rst_inst",    instWord,   32'h0);
      checkOutput("rst_fault",   fetchFault, 1'b0);

      reset = 1'b0;
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      checkOutput("f1_reqv",     reqValid, 1'b1);
      checkOutput("f1_addr",     reqAddr,  32'h8000_0000);

      applyStimulus(1, 0, 0, 0, 0, 0, 0);
      checkOutput("f1_wait_reqv", reqValid, 1'b0);
      applyStimulus(0, 1, 0, 32'h0000_0013, 0, 0, 0);
      checkOutput("f1_instv",    instValid, 1'b1);
      checkOutput("f1_inst",     instWord,  32'h0000_0013);

      applyStimulus(0, 1, 0, 32'hDEAD_BEEF, 0, 1, 32'h8000_0200);
      checkOutput("hold_pc",     pcOut,     32'h8000_0000);
      checkOutput("hold_instv",  instValid, 1'b1);
      checkOutput("hold_inst",   instWord,  32'h0000_0013);

      applyStimulus(0, 0, 0, 0, 1, 0, 0);
      checkOutput("exec_instv",  instValid, 1'b0);
      checkOutput("exec_reqv",   reqValid,  1'b0);

      applyStimulus(0, 0, 0, 0, 0, 1, 32'h8000_0100);
      checkOutput("jmp_pc",      pcOut,    32'h8000_0100);
      checkOutput("jmp_addr",    reqAddr,  32'h8000_0100);
      checkOutput("jmp_reqv",    reqValid, 1'b1);

      for (int i = 0; i < 5; i++) begin
         applyStimulus(0, 1, 0, 32'h1111_1111, 0, 1, 32'h1234_0000);
         checkOutput($sformatf("stall%0d_reqv", i), reqValid, 1'b1);
         checkOutput($sformatf("stall%0d_addr", i), reqAddr,  32'h8000_0100);
      end

      applyStimulus(1, 0, 0, 0, 0, 0, 0);
      checkOutput("acc_count2",  acceptCount, 2);
      applyStimulus(1, 0, 0, 0, 0, 1, 32'h8000_0300);
      checkOutput("wait_pc",     pcOut,    32'h8000_0100);
      checkOutput("wait_reqv",   reqValid, 1'b0);
      checkOutput("wait_acc",    acceptCount, 2);

      reset = 1'b1;
      #1;
      checkOutput("mid_rst_pc",    pcOut,      32'h8000_0000);
      checkOutput("mid_rst_instv", instValid,  1'b0);
      checkOutput("mid_rst_fault", fetchFault, 1'b0);
      checkOutput("mid_rst_inst",  instWord,   32'h0);
      @(posedge clock); #1;
      reset = 1'b0;

      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      checkOutput("refetch_reqv", reqValid, 1'b1);
      checkOutput("refetch_addr", reqAddr,  32'h8000_0000);
      applyStimulus(1, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 1, 0, 32'h0010_0093, 0, 0, 0);
      checkOutput("f3_inst",     instWord, 32'h0010_0093);
      checkOutput("acc_count3",  acceptCount, 3);
      applyStimulus(0, 0, 0, 0, 1, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 1, 32'h8000_0102);
      checkOutput("mis_fault",   fetchFault, 1'b1);
      checkOutput("mis_reqv",    reqValid,   1'b0);
      checkOutput("mis_pc",      pcOut,      32'h8000_0000);

      for (int i = 0; i < 3; i++) begin
         applyStimulus(1, 1, 0, 32'h0000_0013, 1, 1, 32'h8000_0400);
         checkOutput($sformatf("mis_stay%0d_fault", i), fetchFault, 1'b1);
         checkOutput($sformatf("mis_stay%0d_reqv", i),  reqValid,   1'b0);
         checkOutput($sformatf("mis_stay%0d_instv", i), instValid,  1'b0);
         checkOutput($sformatf("mis_stay%0d_pc", i),    pcOut,      32'h8000_0000);
      end

      doReset();
      checkOutput("fr_fault",    fetchFault, 1'b0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 1, 1, 32'h0000_0013, 0, 0, 0);
      checkOutput("err_fault",   fetchFault, 1'b1);
      checkOutput("err_instv",   instValid,  1'b0);
      checkOutput("err_reqv",    reqValid,   1'b0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1, 1, 0, 32'h0000_0013, 1, 1, 32'h8000_0000);
         checkOutput($sformatf("err_stay%0d_fault", i), fetchFault, 1'b1);
         checkOutput($sformatf("err_stay%0d_reqv", i),  reqValid,   1'b0);
      end
      checkOutput("acc_count4",  acceptCount, 4);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
